// File: rtl/rv32i_header.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_header (package)
// Description : Shared encodings for the RV32I writeback stage: load funct3
//               widths and the writeback FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_header;

    // Load width/sign encodings carried in funct3
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    // Writeback FSM states
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_ACK = 2'd1;
    localparam logic [1:0] c_DRAIN    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rv32i_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_load_extend
// Description : Combinational load-data extraction. Picks the addressed
//               byte/halfword out of the memory word and sign- or zero-
//               extends it to 32 bits according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_load_extend
    import rv32i_header::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection; halfword ignores lsb[0] since misalignment traps upstream
    always_comb begin
        w_byte = i_rdata[{i_lsb, 3'b000} +: 8];
        w_half = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension by width/sign; unknown encodings pass the whole word through
    always_comb begin
        case (i_funct3)
            c_LB:    o_data = {{24{w_byte[7]}}, w_byte};
            c_LH:    o_data = {{16{w_half[15]}}, w_half};
            c_LW:    o_data = i_rdata;
            c_LBU:   o_data = {24'd0, w_byte};
            c_LHU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_writeback
// Description : RV32I stage-5 writeback. Retires ALU results immediately,
//               waits for the data-memory acknowledge on loads (stalling
//               upstream meanwhile) and drives the register-file write port
//               from registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_writeback
    import rv32i_header::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_result,
    input  logic        i_ack,
    input  logic [31:0] i_rdata,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_wr,
    output logic        o_stall
);

    logic [1:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lsb;
    logic [4:0]  r_pend_rd_addr;
    logic        r_pend_wr;
    logic        r_wr;
    logic [31:0] r_rd;
    logic [4:0]  r_rd_addr;

    logic        w_idle;
    logic [2:0]  w_funct3;
    logic [1:0]  w_lsb;
    logic [31:0] w_load_data;
    logic        w_wr_now;
    logic        w_wr_pend;

    // In IDLE a same-cycle ack uses the live inputs; otherwise the latched load
    always_comb begin
        w_idle    = (r_state == c_IDLE);
        w_funct3  = w_idle ? i_funct3   : r_funct3;
        w_lsb     = w_idle ? i_addr_lsb : r_lsb;
        w_wr_now  = i_wr_rd   && (i_rd_addr      != 5'd0);
        w_wr_pend = r_pend_wr && (r_pend_rd_addr != 5'd0);
    end

    rv32i_load_extend u_load_extend (
        .i_funct3 (w_funct3),
        .i_lsb    (w_lsb),
        .i_rdata  (i_rdata),
        .o_data   (w_load_data)
    );

    // Writeback FSM and registered register-file port; o_rd/o_rd_addr only
    // change on an actual write so they hold while o_wr is low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= c_IDLE;
            r_funct3       <= 3'd0;
            r_lsb          <= 2'd0;
            r_pend_rd_addr <= 5'd0;
            r_pend_wr      <= 1'b0;
            r_wr           <= 1'b0;
            r_rd           <= 32'd0;
            r_rd_addr      <= 5'd0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_ce && !i_flush) begin
                        if (!i_load) begin
                            r_wr <= w_wr_now;
                            if (w_wr_now) begin
                                r_rd      <= i_result;
                                r_rd_addr <= i_rd_addr;
                            end
                        end else if (i_ack) begin
                            r_wr <= w_wr_now;
                            if (w_wr_now) begin
                                r_rd      <= w_load_data;
                                r_rd_addr <= i_rd_addr;
                            end
                        end else begin
                            r_funct3       <= i_funct3;
                            r_lsb          <= i_addr_lsb;
                            r_pend_rd_addr <= i_rd_addr;
                            r_pend_wr      <= i_wr_rd;
                            r_state        <= c_WAIT_ACK;
                        end
                    end
                end
                c_WAIT_ACK: begin
                    if (i_ack) begin
                        r_state <= c_IDLE;
                        if (!i_flush) begin
                            r_wr <= w_wr_pend;
                            if (w_wr_pend) begin
                                r_rd      <= w_load_data;
                                r_rd_addr <= r_pend_rd_addr;
                            end
                        end
                    end else if (i_flush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (i_ack) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Stall whenever a load is outstanding or being drained
    always_comb begin
        o_stall   = (r_state == c_WAIT_ACK) || (r_state == c_DRAIN);
        o_wr      = r_wr;
        o_rd      = r_rd;
        o_rd_addr = r_rd_addr;
    end

endmodule
`default_nettype wire
